// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the elastic pipeline register chain.
//   occW()     - width of the occupancy counter for a given slot count
//                (must hold values 0 .. STAGES+1: all slots plus the skid entry).
//   FLUSH_ALL  - all-ones flush mask for the default slot count.
package pipe_pkg;

   localparam int DEFAULT_STAGES = 4;

   localparam logic [DEFAULT_STAGES-1:0] FLUSH_ALL = '1;

   function automatic int occW(input int stages);
      return $clog2(stages + 2);
   endfunction

endpackage

// File: rtl/elastic_pipe_if.sv
// elastic_pipe_if: one valid/ready channel carrying a DATA_W payload.
//   valid - sender holds an entry
//   ready - receiver accepts the entry this cycle
//   data  - payload, meaningful only while valid is high
// master = sending side, slave = receiving side.
interface elastic_pipe_if #(
   parameter int DATA_W = 32
);

   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/elastic_stage.sv
// elastic_stage: one slot of the elastic chain (valid bit plus payload).
//   clk, rst_n - clock, synchronous active-low reset
//   load       - slot advances: takes inValid/inData from its predecessor
//   flush      - slot is empty after this edge, overriding load and hold
//   inValid    - predecessor valid
//   inData     - predecessor payload
//   valid      - slot holds an entry
//   data       - slot payload
module elastic_stage #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              flush,
   input  logic              inValid,
   input  logic [DATA_W-1:0] inData,
   output logic              valid,
   output logic [DATA_W-1:0] data
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid <= 1'b0;
         data  <= '0;
      end else begin
         if (flush) begin
            valid <= 1'b0;
         end else if (load) begin
            valid <= inValid;
         end
         // Payload only moves with a real entry, so bubbles never toggle it.
         if (load && inValid) begin
            data <= inData;
         end
      end
   end

endmodule

// File: rtl/elastic_pipe.sv
// elastic_pipe: parametrised elastic register chain with valid/ready
// handshakes, back-pressure, bubble collapsing and per-slot flush.
//   clk, rst_n  - clock, synchronous active-low reset
//   inPort      - producer channel (slave): valid/data in, ready out
//   outPort     - consumer channel (master): valid/data out, ready in
//   flush_mask  - bit i empties slot i at the next edge; bit 0 also drops
//                 the skid entry and any entry accepted in the same cycle
//   occupancy   - number of valid slots plus the skid entry
// SKID=1 adds a one-entry input buffer so inPort.ready is a register output
// and never depends combinationally on outPort.ready.
module elastic_pipe
   import pipe_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int STAGES = 4,
   parameter bit SKID   = 1'b1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   elastic_pipe_if.slave               inPort,
   elastic_pipe_if.master              outPort,
   input  logic [STAGES-1:0]           flush_mask,
   output logic [occW(STAGES)-1:0]     occupancy
);

   localparam int OCC_W = occW(STAGES);

   logic [STAGES-1:0] v;
   logic [STAGES-1:0] adv;
   logic [DATA_W-1:0] d [STAGES];

   logic              inAccept;
   logic              skidValid;
   logic [DATA_W-1:0] skidData;
   logic              srcValid;
   logic [DATA_W-1:0] srcData;

   // A slot may advance if it is empty or everything downstream of it can
   // make room; computed as a running OR from the output end so the vector
   // never feeds back on itself.
   always_comb begin : advChain
      logic room;
      room = outPort.ready;
      for (int i = STAGES - 1; i >= 0; i--) begin
         room   = room | ~v[i];
         adv[i] = room;
      end
   end

   generate
      if (SKID) begin : genSkid
         assign inPort.ready = ~skidValid;
         assign inAccept     = inPort.valid & ~skidValid;

         // An accepted entry parks here only when slot 0 cannot take it;
         // while parked, ready is low so no newer entry can overtake it.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               skidValid <= 1'b0;
               skidData  <= '0;
            end else begin
               if (flush_mask[0]) begin
                  skidValid <= 1'b0;
               end else if (skidValid) begin
                  if (adv[0]) begin
                     skidValid <= 1'b0;
                  end
               end else if (inAccept && !adv[0]) begin
                  skidValid <= 1'b1;
               end
               if (!skidValid && inAccept && !adv[0]) begin
                  skidData <= inPort.data;
               end
            end
         end
      end else begin : genNoSkid
         assign inPort.ready = adv[0];
         assign inAccept     = inPort.valid & adv[0];
         assign skidValid    = 1'b0;
         assign skidData     = '0;
      end
   endgenerate

   // The skid entry is always older than anything on the input port.
   assign srcValid = skidValid | inAccept;
   assign srcData  = skidValid ? skidData : inPort.data;

   for (genvar i = 0; i < STAGES; i++) begin : genStage
      logic              prevValid;
      logic [DATA_W-1:0] prevData;

      if (i == 0) begin : genHead
         assign prevValid = srcValid;
         assign prevData  = srcData;
      end else begin : genBody
         assign prevValid = v[i-1];
         assign prevData  = d[i-1];
      end

      elastic_stage #(
         .DATA_W (DATA_W)
      ) uStage (
         .clk     (clk),
         .rst_n   (rst_n),
         .load    (adv[i]),
         .flush   (flush_mask[i]),
         .inValid (prevValid),
         .inData  (prevData),
         .valid   (v[i]),
         .data    (d[i])
      );
   end

   assign outPort.valid = v[STAGES-1];
   assign outPort.data  = d[STAGES-1];

   always_comb begin
      occupancy = OCC_W'(skidValid);
      for (int i = 0; i < STAGES; i++) begin
         occupancy = occupancy + OCC_W'(v[i]);
      end
   end

endmodule
